// File: rtl/param_commit_ctrl.sv
// Double-buffered parameter bank: host writes land in staging registers and are
// copied to the live bank in one clk cycle on the next rising edge of sim_clk.
module param_commit_ctrl #(
  parameter int NP          = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_global,
  input  logic                wr_stb,
  input  logic [3:0]          wr_addr,
  input  logic [31:0]         wr_data,
  input  logic                commit_req,
  input  logic                abort,
  input  logic                sim_clk,
  output logic [32*NP-1:0]    params_out,
  output logic [NP-1:0]       pending,
  output logic                busy,
  output logic                commit_done,
  output logic                addr_err,
  output logic [1:0]          fsm_state
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] COPY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic logic [31:0] rst_val(input int k);
    case (k)
      1:       rst_val = 32'h3E80_0000;
      3:       rst_val = 32'h42A0_0000;
      4:       rst_val = 32'h42A0_0000;
      5:       rst_val = 32'h0000_0001;
      6:       rst_val = 32'h3E71_4120;
      7:       rst_val = 32'h3D14_4674;
      8:       rst_val = 32'h3C58_44D0;
      9:       rst_val = 32'h469C_4000;
      default: rst_val = 32'h0000_0000;
    endcase
  endfunction

  logic [1:0]             state_q;
  logic [1:0]             state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sim_rise;
  logic                   copy_en;
  logic [31:0]            addr_ext;

  assign addr_ext = {28'd0, wr_addr};
  assign sim_rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign copy_en  = (state_q == COPY);

  // sim_clk is asynchronous to clk; it only ever feeds this flop chain.
  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sim_clk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // abort wins over a simultaneous sim_rise; commit_req outside IDLE is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (commit_req) state_d = ARMED;
      ARMED:   if (abort) state_d = IDLE;
               else if (sim_rise) state_d = COPY;
      COPY:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_global) begin
    if (reset_global) begin
      state_q  <= IDLE;
      addr_err <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_err <= wr_stb && (addr_ext >= NP);
    end
  end

  assign busy        = (state_q == ARMED) || (state_q == COPY);
  assign commit_done = (state_q == DONE);
  assign fsm_state   = state_q;

  for (genvar k = 0; k < NP; k++) begin : gen_idx
    localparam logic [31:0] RST = rst_val(k);
    logic [31:0] staging_q;
    logic [31:0] live_q;
    logic        pend_q;
    logic        wr_hit;

    assign wr_hit = wr_stb && (addr_ext == 32'(k));

    // A write landing in the COPY cycle is not copied: live takes the old
    // staging value while staging takes the new one and stays pending.
    always_ff @(posedge clk or posedge reset_global) begin
      if (reset_global) begin
        staging_q <= RST;
        live_q    <= RST;
        pend_q    <= 1'b0;
      end else begin
        if (copy_en && pend_q) live_q <= staging_q;
        if (wr_hit) begin
          staging_q <= wr_data;
          pend_q    <= 1'b1;
        end else if (copy_en) begin
          pend_q    <= 1'b0;
        end
      end
    end

    assign params_out[32*k +: 32] = live_q;
    assign pending[k]             = pend_q;
  end

endmodule

// File: tb/tb_param_commit_ctrl.sv
// Directed bench for param_commit_ctrl: a reference bank model feeds an expected
// queue at commit time; commit_done pops and compares the live bank.
module tb_param_commit_ctrl;
  localparam int NP = 10;
  localparam int W  = 32 * NP;

  logic          clk = 1'b0;
  logic          reset_global;
  logic          wr_stb;
  logic [3:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          commit_req;
  logic          abort;
  logic          sim_clk;
  logic [W-1:0]  params_out;
  logic [NP-1:0] pending;
  logic          busy;
  logic          commit_done;
  logic          addr_err;
  logic [1:0]    fsm_state;

  param_commit_ctrl #(.NP(NP), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_global(reset_global), .wr_stb(wr_stb), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit_req(commit_req), .abort(abort), .sim_clk(sim_clk),
    .params_out(params_out), .pending(pending), .busy(busy),
    .commit_done(commit_done), .addr_err(addr_err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [31:0]  m_stage[NP];
  logic [31:0]  m_live[NP];
  logic         m_pend[NP];

  always @(posedge clk) if (commit_done) done_cnt++;

  function automatic logic [31:0] init_val(input int k);
    logic [31:0] tbl [10] = '{32'h00000000, 32'h3E800000, 32'h00000000, 32'h42A00000,
                              32'h42A00000, 32'h00000001, 32'h3E714120, 32'h3D144674,
                              32'h3C5844D0, 32'h469C4000};
    return (k < 10) ? tbl[k] : 32'h0;
  endfunction

  function automatic logic [W-1:0] pack_live();
    logic [W-1:0] v;
    for (int k = 0; k < NP; k++) v[32*k +: 32] = m_live[k];
    return v;
  endfunction

  function automatic logic [NP-1:0] pack_pend();
    logic [NP-1:0] v;
    for (int k = 0; k < NP; k++) v[k] = m_pend[k];
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NP; k++) begin
      m_stage[k] = init_val(k);
      m_live[k]  = init_val(k);
      m_pend[k]  = 1'b0;
    end
  endtask

  task automatic model_copy();
    for (int k = 0; k < NP; k++)
      if (m_pend[k]) begin
        m_live[k] = m_stage[k];
        m_pend[k] = 1'b0;
      end
    exp_q.push_back(pack_live());
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [3:0] a, input logic [31:0] d);
    wr_stb = 1'b1; wr_addr = a; wr_data = d;
    if (int'(a) < NP) begin
      m_stage[a] = d;
      m_pend[a]  = 1'b1;
    end
    tick();
    wr_stb = 1'b0;
  endtask

  task automatic arm();
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
  endtask

  task automatic fire(input string tag);
    int  start;
    bit  seen;
    start = done_cnt;
    seen  = 1'b0;
    model_copy();
    sim_clk = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (commit_done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, W'(seen), W'(1));
    if (seen) begin
      chk({tag, "_params"}, params_out, exp_q.pop_front());
      chk({tag, "_pending"}, W'(pending), W'(pack_pend()));
    end
    repeat (4) tick();
    sim_clk = 1'b0;
    repeat (4) tick();
    chk({tag, "_one_pulse"}, W'(done_cnt - start), W'(1));
    chk({tag, "_idle"}, W'(busy), W'(0));
  endtask

  initial begin
    int start;
    reset_global = 1'b1; wr_stb = 1'b0; wr_addr = '0; wr_data = '0;
    commit_req = 1'b0; abort = 1'b0; sim_clk = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_params", params_out, pack_live());
    chk("rst_pending", W'(pending), W'(0));
    chk("rst_flags", W'({busy, commit_done, addr_err}), W'(0));
    reset_global = 1'b0;
    tick();

    // single-parameter commit with exact update timing
    write(4'd3, 32'h42C80000);
    chk("wr3_pending", W'(pending), W'(10'b0000001000));
    chk("wr3_live_held", W'(params_out[127:96]), W'(32'h42A00000));
    arm();
    chk("arm_busy", W'(busy), W'(1));
    start = done_cnt;
    model_copy();
    sim_clk = 1'b1;
    tick(); tick();
    chk("rise_seen_old", W'(params_out[127:96]), W'(32'h42A00000));
    tick();
    chk("copy_cycle_old", W'(params_out[127:96]), W'(32'h42A00000));
    chk("copy_cycle_pend", W'(pending[3]), W'(1));
    tick();
    chk("done_pulse", W'(commit_done), W'(1));
    chk("done_params", params_out, exp_q.pop_front());
    chk("done_pend_clr", W'(pending), W'(0));
    tick();
    chk("done_one_cycle", W'(commit_done), W'(0));
    sim_clk = 1'b0;
    repeat (4) tick();
    chk("done_count", W'(done_cnt - start), W'(1));

    // rejected writes, including the first index past the bank
    write(4'd12, 32'hDEADBEEF);
    chk("err12_pulse", W'(addr_err), W'(1));
    chk("err12_pending", W'(pending), W'(0));
    chk("err12_params", params_out, pack_live());
    tick();
    chk("err12_clear", W'(addr_err), W'(0));
    write(4'd10, 32'h12345678);
    chk("err10_pulse", W'(addr_err), W'(1));
    write(4'd9, 32'h0BADF00D);
    chk("ok9_no_err", W'(addr_err), W'(0));
    chk("ok9_pending", W'(pending), W'(10'b1000000000));

    // abort in the same cycle as sim_rise
    write(4'd7, 32'h11112222);
    arm();
    start = done_cnt;
    sim_clk = 1'b1;
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", W'(busy), W'(0));
    chk("abort_pending", W'(pending), W'(pack_pend()));
    chk("abort_params", params_out, pack_live());
    repeat (4) tick();
    sim_clk = 1'b0;
    repeat (4) tick();
    chk("abort_no_done", W'(done_cnt - start), W'(0));
    arm();
    fire("after_abort");

    // write landing in the COPY cycle
    write(4'd5, 32'd4);
    arm();
    start = done_cnt;
    sim_clk = 1'b1;
    tick(); tick(); tick();
    chk("copy_state", W'(fsm_state), W'(2));
    model_copy();
    wr_stb = 1'b1; wr_addr = 4'd5; wr_data = 32'd7;
    m_stage[5] = 32'd7; m_pend[5] = 1'b1;
    tick();
    wr_stb = 1'b0;
    chk("copy_wr_done", W'(commit_done), W'(1));
    chk("copy_wr_live", params_out, exp_q.pop_front());
    chk("copy_wr_pend", W'(pending), W'(10'b0000100000));
    repeat (3) tick();
    sim_clk = 1'b0;
    repeat (4) tick();
    arm();
    fire("staged7");

    // repeated commit_req while armed, then an empty commit
    write(4'd2, 32'hABCD0001);
    arm();
    commit_req = 1'b1; tick(); tick(); commit_req = 1'b0;
    fire("double_req");
    arm();
    fire("empty_commit");

    // asynchronous reset while armed
    write(4'd4, 32'h12345678);
    arm();
    start = done_cnt;
    sim_clk = 1'b1;
    #2;
    reset_global = 1'b1;
    #1;
    model_reset();
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_pending", W'(pending), W'(0));
    chk("arst_params", params_out, pack_live());
    tick(); tick();
    reset_global = 1'b0;
    repeat (8) tick();
    sim_clk = 1'b0;
    repeat (4) tick();
    chk("arst_no_done", W'(done_cnt - start), W'(0));
    chk("arst_params_hold", params_out, pack_live());

    // random-value commit across several indices
    for (int i = 0; i < 4; i++)
      write(4'($urandom_range(0, NP - 1)), $urandom_range(0, 32'h7FFFFFFF));
    arm();
    fire("random");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
